// File: rtl/lab_pkg.sv
// Shared types and key code constants for the lab key/display path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lab_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    // Same code space as the seven-segment letter decoder: KEYn -> code n.
    localparam logic [3:0] CODE_A = 4'd0;
    localparam logic [3:0] CODE_P = 4'd1;
    localparam logic [3:0] CODE_E = 4'd2;
    localparam logic [3:0] CODE_1 = 4'd3;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // Only meaningful for a one-hot vector; other patterns fall back to CODE_A.
    function automatic logic [3:0] onehot_to_code(input logic [3:0] v);
        logic [3:0] code;
        case (v)
            4'b0001: code = CODE_A;
            4'b0010: code = CODE_P;
            4'b0100: code = CODE_E;
            4'b1000: code = CODE_1;
            default: code = CODE_A;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/key_code_encoder_if.sv
// Button inputs and key code outputs of the key code encoder.
// Latency: n/a (wiring only).
// Backpressure: none; outputs are pulses/levels with no ready.
interface key_code_encoder_if;
    logic [3:0]  KEY;
    logic [3:0]  Code;
    logic        Code_valid;
    logic        Multi;
    logic [15:0] Hist;
    logic [7:0]  Count;

    // Stimulus side: drives buttons, observes codes.
    modport master (
        output KEY,
        input  Code, Code_valid, Multi, Hist, Count
    );

    // Encoder side.
    modport slave (
        input  KEY,
        output Code, Code_valid, Multi, Hist, Count
    );
endinterface

// File: rtl/key_sync.sv
// Two-flop synchroniser for an asynchronous bus, reset to all ones (released).
// Latency: 2 cycles.
// Backpressure: none.
module key_sync #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture of the asynchronous inputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/key_code_encoder.sv
// Debounces four active-low buttons and emits one key code per press-release cycle.
// Latency: DEBOUNCE_CYCLES+2 cycles from first low sample of KEY to Code_valid.
// Backpressure: none; presses arriving while a press is held are ignored.
module key_code_encoder
    import lab_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 CLOCK_50,
    input  logic                 RST_N,
    key_code_encoder_if.slave    bus
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    // The state change happens on the edge where the counter would reach
    // DEBOUNCE_CYCLES-1, so compare against the value one below it.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

    logic [3:0]    w_ks;
    logic [3:0]    w_down;
    logic          w_any_down;

    state_e        r_state;
    state_e        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [3:0]    r_pv;
    logic [3:0]    w_pv_nxt;
    logic          w_accept;
    logic          w_multi;
    logic [3:0]    w_code;

    logic [3:0]    r_code;
    logic          r_code_vld;
    logic          r_multi;
    logic [15:0]   r_hist;
    logic [7:0]    r_count;

    key_sync #(.WIDTH(4)) u_key_sync (
        .i_clk   (CLOCK_50),
        .i_rst_n (RST_N),
        .i_d     (bus.KEY),
        .o_q     (w_ks)
    );

    assign w_down     = ~w_ks;
    assign w_any_down = |w_down;
    assign w_code     = onehot_to_code(r_pv);

    // FSM state, debounce counter and latched press vector.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pv    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pv    <= w_pv_nxt;
        end
    end

    // Next state, counter update and press accept/multi decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pv_nxt    = r_pv;
        w_accept    = 1'b0;
        w_multi     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_down) begin
                    w_pv_nxt    = w_down;
                    w_cnt_nxt   = '0;
                    w_state_nxt = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (w_down != r_pv) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = HELD;
                    if (popcnt4(r_pv) == 3'd1) begin
                        w_accept = 1'b1;
                    end else if (popcnt4(r_pv) > 3'd1) begin
                        w_multi = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            HELD: begin
                if (!w_any_down) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (w_any_down) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs: pulses every cycle, code/history/count only on accept.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_code     <= CODE_A;
            r_code_vld <= 1'b0;
            r_multi    <= 1'b0;
            r_hist     <= 16'h0000;
            r_count    <= 8'h00;
        end else begin
            r_code_vld <= w_accept;
            r_multi    <= w_multi;
            if (w_accept) begin
                r_code  <= w_code;
                r_hist  <= {r_hist[11:0], w_code};
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign bus.Code       = r_code;
    assign bus.Code_valid = r_code_vld;
    assign bus.Multi      = r_multi;
    assign bus.Hist       = r_hist;
    assign bus.Count      = r_count;

endmodule

// File: tb/tb_key_code_encoder.sv
// Directed bench for key_code_encoder with DEBOUNCE_CYCLES=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_key_code_encoder;

    logic CLOCK_50 = 1'b0;
    logic RST_N;

    always #5 CLOCK_50 = ~CLOCK_50;

    key_code_encoder_if bus ();

    key_code_encoder #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .RST_N    (RST_N),
        .bus      (bus)
    );

    int checks   = 0;
    int errors   = 0;
    int n_cv     = 0;
    int n_mu     = 0;
    int n_both   = 0;
    int t        = 0;
    int first_cv = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_cv     = 0;
        n_mu     = 0;
        t        = 0;
        first_cv = -1;
    endtask

    // Advance n cycles, sampling 1 time unit after each rising edge.
    task automatic tick(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge CLOCK_50);
            #1;
            t++;
            if (bus.Code_valid === 1'b1) begin
                n_cv++;
                if (first_cv < 0) first_cv = t;
            end
            if (bus.Multi === 1'b1) n_mu++;
            if (bus.Code_valid === 1'b1 && bus.Multi === 1'b1) n_both++;
        end
    endtask

    initial begin
        logic [3:0] key;

        // 1: reset with random buttons, then idle with buttons released
        RST_N   = 1'b0;
        bus.KEY = 4'($urandom);
        for (int i = 0; i < 5; i++) begin
            bus.KEY = 4'($urandom);
            tick(1);
        end
        chk("rst_code",  32'(bus.Code), 32'h0);
        chk("rst_vld",   32'(bus.Code_valid), 32'h0);
        chk("rst_multi", 32'(bus.Multi), 32'h0);
        chk("rst_hist",  32'(bus.Hist), 32'h0);
        chk("rst_count", 32'(bus.Count), 32'h0);
        bus.KEY = 4'hF;
        RST_N   = 1'b1;
        clr();
        tick(50);
        chk("idle_cv",    32'(n_cv), 32'd0);
        chk("idle_multi", 32'(n_mu), 32'd0);
        chk("idle_code",  32'(bus.Code), 32'h0);
        chk("idle_hist",  32'(bus.Hist), 32'h0);
        chk("idle_count", 32'(bus.Count), 32'h0);

        // 2: single press of KEY2
        clr();
        bus.KEY = 4'b1011;
        tick(30);
        bus.KEY = 4'hF;
        tick(20);
        chk("k2_cv",      32'(n_cv), 32'd1);
        chk("k2_latency", 32'(first_cv), 32'd6);
        chk("k2_multi",   32'(n_mu), 32'd0);
        chk("k2_code",    32'(bus.Code), 32'h2);
        chk("k2_hist",    32'(bus.Hist), 32'h0002);
        chk("k2_count",   32'(bus.Count), 32'h01);

        // 3: KEY1 with a short bounce before a solid press
        clr();
        bus.KEY = 4'b1101;
        tick(2);
        bus.KEY = 4'hF;
        tick(1);
        bus.KEY = 4'b1101;
        tick(30);
        bus.KEY = 4'hF;
        tick(20);
        chk("bnc_cv",      32'(n_cv), 32'd1);
        chk("bnc_latency", 32'(first_cv), 32'd9);
        chk("bnc_code",    32'(bus.Code), 32'h1);
        chk("bnc_hist",    32'(bus.Hist), 32'h0021);
        chk("bnc_count",   32'(bus.Count), 32'h02);

        // 4: KEY0 and KEY3 together
        clr();
        bus.KEY = 4'b0110;
        tick(30);
        bus.KEY = 4'hF;
        tick(20);
        chk("mk_multi", 32'(n_mu), 32'd1);
        chk("mk_cv",    32'(n_cv), 32'd0);
        chk("mk_code",  32'(bus.Code), 32'h1);
        chk("mk_hist",  32'(bus.Hist), 32'h0021);
        chk("mk_count", 32'(bus.Count), 32'h02);

        // 5: KEY0..KEY3 in rotation from reset, 256 presses for the wrap
        RST_N = 1'b0;
        tick(2);
        RST_N = 1'b1;
        clr();
        for (int i = 0; i < 256; i++) begin
            key     = 4'(~(4'd1 << (i % 4)));
            bus.KEY = key;
            tick(10);
            bus.KEY = 4'hF;
            tick(10);
            if (i == 3) begin
                chk("seq4_hist",  32'(bus.Hist), 32'h0123);
                chk("seq4_count", 32'(bus.Count), 32'h04);
            end
            if (i == 254) begin
                chk("seq255_count", 32'(bus.Count), 32'hFF);
            end
        end
        chk("wrap_cv",    32'(n_cv), 32'd256);
        chk("wrap_count", 32'(bus.Count), 32'h00);
        chk("wrap_hist",  32'(bus.Hist), 32'h0123);
        chk("wrap_code",  32'(bus.Code), 32'h3);

        // 6: reset pulse during debounce of a held KEY2
        clr();
        bus.KEY = 4'b1011;
        tick(4);
        RST_N = 1'b0;
        #1;
        chk("mid_rst_vld",   32'(bus.Code_valid), 32'h0);
        chk("mid_rst_count", 32'(bus.Count), 32'h00);
        chk("mid_rst_hist",  32'(bus.Hist), 32'h0000);
        tick(2);
        chk("mid_rst_cv", 32'(n_cv), 32'd0);
        RST_N = 1'b1;
        clr();
        tick(20);
        chk("post_rst_cv",      32'(n_cv), 32'd1);
        chk("post_rst_latency", 32'(first_cv), 32'd6);
        chk("post_rst_code",    32'(bus.Code), 32'h2);
        chk("post_rst_hist",    32'(bus.Hist), 32'h0002);
        chk("post_rst_count",   32'(bus.Count), 32'h01);
        clr();
        tick(100);
        chk("hold_cv", 32'(n_cv), 32'd0);
        bus.KEY = 4'hF;
        tick(20);

        chk("never_both", 32'(n_both), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
